// File: rtl/trace_pkg.sv
// Shared types for the instruction trace sequencer: event payload and FSM states.
package trace_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRACE_CYCLE_W = 64;

    // One retired instruction as seen by the tracer.
    typedef struct packed {
        logic [XLEN-1:0]          npc;
        logic [XLEN-1:0]          inst;
        logic [XLEN-1:0]          mtvec;
        logic [XLEN-1:0]          mepc;
        logic [TRACE_CYCLE_W-1:0] cycle;
    } trace_evt_t;

    // RUN accepts and drains, DRAIN only drains, DONE idles until reset.
    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_DRAIN = 2'd1,
        SEQ_DONE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO holding trace events between the commit port and the tracer.
// Ports:
//   clock      - clock, all updates on posedge
//   reset      - asynchronous active-low reset (pointers only; storage is don't-care when empty)
//   push       - write push_data at the tail (ignored when full)
//   push_data  - entry to write
//   pop        - drop the head entry (ignored when empty)
//   full/empty - occupancy flags from the current pointers
//   last       - exactly one entry buffered
//   head       - current head entry (undefined when empty)
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = trace_evt_t
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic last,
    output T     head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] level;
    logic          push_ok;
    logic          pop_ok;
    T              mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        level   = wr_ptr - rd_ptr;
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        last    = (level == PW'(1));
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        head    = mem[rd_ptr[AW-1:0]];
    end

    // Pointer update; wrap-around is natural modulo 2*DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage write.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/inst_trace_sequencer.sv
// Buffers retire events from the commit stage and hands them to the instruction
// tracer, one per cycle, each stamped with the RUN cycles elapsed since the previous
// accepted retire. A halt stops intake, drains the buffer, then raises done.
// Ports:
//   clock, reset                    - clock and asynchronous active-low reset
//   in_valid/in_ready               - commit-side handshake
//   in_npc/in_inst/in_mtvec/in_mepc - retired instruction snapshot
//   halt                            - stop accepting commits (pulse or level, RUN only)
//   trace_ready                     - tracer can consume this cycle
//   trace_en                        - head event transferred this cycle
//   trace_npc..trace_cycle          - head event payload, zero when the buffer is empty
//   done                            - drain complete, sticky until reset
module inst_trace_sequencer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CYCLE_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_npc,
    input  logic [31:0]        in_inst,
    input  logic [31:0]        in_mtvec,
    input  logic [31:0]        in_mepc,
    input  logic               halt,
    input  logic               trace_ready,
    output logic               trace_en,
    output logic [31:0]        trace_npc,
    output logic [31:0]        trace_inst,
    output logic [31:0]        trace_mtvec,
    output logic [31:0]        trace_mepc,
    output logic [CYCLE_W-1:0] trace_cycle,
    output logic               done
);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [CYCLE_W-1:0] elapsed_q;
    logic [CYCLE_W-1:0] elapsed_d;
    logic [CYCLE_W-1:0] stamp;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_last;
    trace_evt_t         push_evt;
    trace_evt_t         head_evt;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: DRAIN finishes once the buffer is empty after this cycle's pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_RUN: begin
                if (halt) begin
                    state_d = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                if (fifo_empty || (fifo_last && pop)) begin
                    state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_DONE;
            end
            default: begin
                state_d = SEQ_RUN;
            end
        endcase
    end

    // FSM outputs; in_ready uses pre-pop occupancy, so a full buffer never bypasses.
    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            SEQ_RUN:   in_ready = ~fifo_full;
            SEQ_DONE:  done     = 1'b1;
            default: begin
                in_ready = 1'b0;
                done     = 1'b0;
            end
        endcase
    end

    // Handshakes and stamp; the stamp saturates together with the elapsed counter.
    always_comb begin
        push  = in_valid & in_ready;
        pop   = ~fifo_empty & trace_ready;
        stamp = (&elapsed_q) ? elapsed_q : elapsed_q + CYCLE_W'(1);

        elapsed_d = elapsed_q;
        if (state_q == SEQ_RUN) begin
            elapsed_d = push ? '0 : stamp;
        end

        push_evt.npc   = in_npc;
        push_evt.inst  = in_inst;
        push_evt.mtvec = in_mtvec;
        push_evt.mepc  = in_mepc;
        push_evt.cycle = TRACE_CYCLE_W'(stamp);
    end

    // Elapsed-cycle counter, frozen outside RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_evt_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .last      (fifo_last),
        .head      (head_evt)
    );

    // Tracer side: payload is the head entry, forced to zero while empty.
    always_comb begin
        trace_en    = pop;
        trace_npc   = '0;
        trace_inst  = '0;
        trace_mtvec = '0;
        trace_mepc  = '0;
        trace_cycle = '0;
        if (!fifo_empty) begin
            trace_npc   = head_evt.npc;
            trace_inst  = head_evt.inst;
            trace_mtvec = head_evt.mtvec;
            trace_mepc  = head_evt.mepc;
            trace_cycle = CYCLE_W'(head_evt.cycle);
        end
    end

endmodule

// File: tb/tb_inst_trace_sequencer.sv
// Scoreboard bench for inst_trace_sequencer: a queue-based reference model predicts
// handshakes and stamps; a negedge monitor checks every delivered event in order.
module tb_inst_trace_sequencer;
    import trace_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CYCLE_W = 64;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_npc = '0;
    logic [31:0]        in_inst = '0;
    logic [31:0]        in_mtvec = '0;
    logic [31:0]        in_mepc = '0;
    logic               halt = 1'b0;
    logic               trace_ready = 1'b0;
    logic               trace_en;
    logic [31:0]        trace_npc;
    logic [31:0]        trace_inst;
    logic [31:0]        trace_mtvec;
    logic [31:0]        trace_mepc;
    logic [CYCLE_W-1:0] trace_cycle;
    logic               done;

    always #5 clock = ~clock;

    inst_trace_sequencer #(
        .DEPTH   (DEPTH),
        .CYCLE_W (CYCLE_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_npc      (in_npc),
        .in_inst     (in_inst),
        .in_mtvec    (in_mtvec),
        .in_mepc     (in_mepc),
        .halt        (halt),
        .trace_ready (trace_ready),
        .trace_en    (trace_en),
        .trace_npc   (trace_npc),
        .trace_inst  (trace_inst),
        .trace_mtvec (trace_mtvec),
        .trace_mepc  (trace_mepc),
        .trace_cycle (trace_cycle),
        .done        (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffered events, phase (0 run, 1 drain, 2 done), run-cycle clock.
    trace_evt_t mdl_q[$];
    trace_evt_t sb_q[$];
    int         mdl_state = 0;
    longint     run_cycle = 0;
    longint     last_acc  = -1;
    trace_evt_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transfer must match the oldest outstanding expected event.
    always @(negedge clock) begin
        if (reset && trace_en) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got trace_en=1 expected no event at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("evt_npc",   64'(trace_npc),   64'(mon_e.npc));
                check("evt_inst",  64'(trace_inst),  64'(mon_e.inst));
                check("evt_mtvec", 64'(trace_mtvec), 64'(mon_e.mtvec));
                check("evt_mepc",  64'(trace_mepc),  64'(mon_e.mepc));
                check("evt_cycle", 64'(trace_cycle), 64'(mon_e.cycle));
            end
        end
    end

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input logic v, input logic tr, input logic h, input logic [31:0] inst);
        trace_evt_t ev;
        logic       exp_rdy;
        logic       exp_en;
        ev.npc   = $urandom;
        ev.inst  = inst;
        ev.mtvec = $urandom;
        ev.mepc  = $urandom;
        ev.cycle = '0;
        in_valid    = v;
        in_npc      = ev.npc;
        in_inst     = ev.inst;
        in_mtvec    = ev.mtvec;
        in_mepc     = ev.mepc;
        trace_ready = tr;
        halt        = h;
        #1;
        exp_rdy = (mdl_state == 0) && (mdl_q.size() < DEPTH);
        exp_en  = (mdl_q.size() > 0) && tr;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("trace_en", 64'(trace_en), 64'(exp_en));
        check("done",     64'(done),     64'(mdl_state == 2));
        if (mdl_q.size() == 0) begin
            check("idle_cycle", 64'(trace_cycle), 64'(0));
            check("idle_inst",  64'(trace_inst),  64'(0));
        end
        if (exp_en) begin
            void'(mdl_q.pop_front());
        end
        if (v && exp_rdy) begin
            ev.cycle = 64'(run_cycle - last_acc);
            last_acc = run_cycle;
            mdl_q.push_back(ev);
            sb_q.push_back(ev);
        end
        case (mdl_state)
            0: begin
                run_cycle++;
                if (h) mdl_state = 1;
            end
            1: if (mdl_q.size() == 0) mdl_state = 2;
            default: mdl_state = 2;
        endcase
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        in_valid    = 1'b1;
        trace_ready = 1'b1;
        halt        = 1'b0;
        reset       = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready),    64'(1));
        check("rst_trace_en", 64'(trace_en),    64'(0));
        check("rst_done",     64'(done),        64'(0));
        check("rst_cycle",    64'(trace_cycle), 64'(0));
        check("rst_npc",      64'(trace_npc),   64'(0));
        mdl_q.delete();
        sb_q.delete();
        mdl_state = 0;
        run_cycle = 0;
        last_acc  = -1;
        in_valid  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;

        // Single accept, delivered the next cycle with stamp 1.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0010_0073);
        check("t1_en",    64'(trace_en),    64'(1));
        check("t1_inst",  64'(trace_inst),  64'(32'h0010_0073));
        check("t1_cycle", 64'(trace_cycle), 64'(1));
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Accepts three idle cycles apart: stamps 1, 4, 4.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h11);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h22);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h33);
        check("t2_cycle", 64'(trace_cycle), 64'(4));
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Fill with tracer stalled, then drain.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'(i));
        check("t3_full_ready", 64'(in_ready), 64'(0));
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Halt with an accept, two already queued: three drained then done.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'hA0);
        step(1'b1, 1'b0, 1'b0, 32'hA1);
        step(1'b1, 1'b0, 1'b1, 32'hA2);
        step(1'b1, 1'b0, 1'b0, 32'hA3);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("t4_done", 64'(done), 64'(1));
        step(1'b1, 1'b1, 1'b1, 32'hA4);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Full buffer with pop and valid: no push that cycle, push the next.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'(16 + i));
        step(1'b1, 1'b1, 1'b0, 32'hB0);
        step(1'b1, 1'b1, 1'b0, 32'hB1);
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Reset mid-DRAIN with two queued, then a fresh accept stamped 1.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'hC0);
        step(1'b1, 1'b0, 1'b0, 32'hC1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'hC2);
        check("t6_cycle", 64'(trace_cycle), 64'(1));
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Randomized rounds; odd rounds are cut short by reset, even rounds drain fully.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
                     1'($urandom_range(0, 79) == 0), $urandom);
            end
            if (r % 2 == 0) begin
                step(1'($urandom_range(0, 1)), 1'b1, 1'b1, $urandom);
                repeat (DEPTH + 2) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, $urandom);
                check("rnd_done",     64'(done),        64'(1));
                check("rnd_sb_empty", 64'(sb_q.size()), 64'(0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
